// File: rtl/octal_ram_mr_readback.sv
// Mode-register bring-up sequencer: writes the MR group, reads back the read group and flags mismatches.
// Optional MR_RD_CAPTURE_EN adds a per-read capture array readable through iCapSel/oCapData.
module octal_ram_mr_readback #(
    parameter int WR_FIRST = 0,
    parameter int WR_NUM   = 4,
    parameter int RD_FIRST = 4,
    parameter int RD_NUM   = 6,
    parameter int TIMEOUT  = 255
) (
    input  logic       iClk,
    input  logic       iRst_N,
    input  logic       iStart,
    output logic [7:0] oCfgNo,
    input  logic [7:0] iCfgAddr,
    input  logic [7:0] iCfgData,
    output logic       oCmdReq,
    output logic       oCmdWr,
    output logic [7:0] oCmdAddr,
    output logic [7:0] oCmdData,
    input  logic       iCmdAck,
    input  logic       iRdValid,
    input  logic [7:0] iRdData,
    output logic       oBusy,
    output logic       oDone,
    output logic       oPass,
    output logic       oTimeout,
`ifdef MR_RD_CAPTURE_EN
    input  logic [2:0] iCapSel,
    output logic [7:0] oCapData,
`endif
    output logic [7:0] oErrMask
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_RD_DATA, S_DONE
    } state_t;

    localparam logic [2:0] WR_LAST  = 3'(WR_NUM - 1);
    localparam logic [2:0] RD_LAST  = 3'(RD_NUM - 1);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg, state_next;
    logic [7:0] cfg_no_reg, cfg_no_next;
    logic       req_reg, req_next;
    logic       wr_reg, wr_next;
    logic [7:0] addr_reg, addr_next;
    logic [7:0] data_reg, data_next;
    logic [2:0] wr_idx_reg, wr_idx_next;
    logic [2:0] rd_idx_reg, rd_idx_next;
    logic [7:0] tmo_reg, tmo_next;
    logic       done_reg, done_next;
    logic       timeout_reg, timeout_next;
    logic [7:0] err_reg, err_next;

    logic [7:0]        sh_addr_reg [WR_NUM];
    logic [7:0]        sh_data_reg [WR_NUM];
    logic [WR_NUM-1:0] sh_vld_reg;
    logic [WR_NUM-1:0] hit;
    logic              sh_we, sh_clr, rd_take, exp_hit;
    logic [7:0]        exp_data;

    // A read MA is compared only against slots written during this run.
    generate
        for (genvar gi = 0; gi < WR_NUM; gi++) begin : g_hit
            assign hit[gi] = sh_vld_reg[gi] && (sh_addr_reg[gi] == addr_reg);
        end
    endgenerate

    // Later writes to the same MA override earlier ones.
    always_comb begin
        exp_hit  = 1'b0;
        exp_data = 8'h00;
        for (int j = 0; j < WR_NUM; j++) begin
            if (hit[j]) begin
                exp_hit  = 1'b1;
                exp_data = sh_data_reg[j];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cfg_no_next  = cfg_no_reg;
        req_next     = req_reg;
        wr_next      = wr_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        wr_idx_next  = wr_idx_reg;
        rd_idx_next  = rd_idx_reg;
        tmo_next     = tmo_reg;
        done_next    = done_reg;
        timeout_next = timeout_reg;
        err_next     = err_reg;
        sh_we        = 1'b0;
        sh_clr       = 1'b0;
        rd_take      = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (iStart) begin
                    done_next    = 1'b0;
                    timeout_next = 1'b0;
                    err_next     = 8'h00;
                    cfg_no_next  = 8'(WR_FIRST);
                    wr_idx_next  = 3'd0;
                    rd_idx_next  = 3'd0;
                    sh_clr       = 1'b1;
                    state_next   = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                addr_next  = iCfgAddr;
                data_next  = iCfgData;
                wr_next    = 1'b1;
                req_next   = 1'b1;
                sh_we      = 1'b1;
                tmo_next   = 8'd0;
                state_next = S_WR_WAIT;
            end
            S_RD_REQ: begin
                addr_next  = iCfgAddr;
                data_next  = 8'h00;
                wr_next    = 1'b0;
                req_next   = 1'b1;
                tmo_next   = 8'd0;
                state_next = S_RD_WAIT;
            end
            S_WR_WAIT, S_RD_WAIT, S_RD_DATA: begin
                if (state_reg == S_WR_WAIT && iCmdAck) begin
                    req_next = 1'b0;
                    if (wr_idx_reg == WR_LAST) begin
                        cfg_no_next = 8'(RD_FIRST);
                        state_next  = S_RD_REQ;
                    end else begin
                        cfg_no_next = cfg_no_reg + 8'd1;
                        wr_idx_next = wr_idx_reg + 3'd1;
                        state_next  = S_WR_REQ;
                    end
                end else if (state_reg == S_RD_WAIT && iCmdAck) begin
                    req_next = 1'b0;
                    if (iRdValid) begin
                        rd_take = 1'b1;
                    end else begin
                        tmo_next   = 8'd0;
                        state_next = S_RD_DATA;
                    end
                end else if (state_reg == S_RD_DATA && iRdValid) begin
                    rd_take = 1'b1;
                end else if (tmo_reg == TMO_LAST) begin
                    timeout_next = 1'b1;
                    req_next     = 1'b0;
                    done_next    = 1'b1;
                    state_next   = S_DONE;
                end else begin
                    tmo_next = tmo_reg + 8'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (rd_take) begin
            if (exp_hit && (iRdData != exp_data))
                err_next[rd_idx_reg] = 1'b1;
            if (rd_idx_reg == RD_LAST) begin
                done_next  = 1'b1;
                state_next = S_DONE;
            end else begin
                rd_idx_next = rd_idx_reg + 3'd1;
                cfg_no_next = cfg_no_reg + 8'd1;
                state_next  = S_RD_REQ;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            state_reg   <= S_IDLE;
            cfg_no_reg  <= 8'h00;
            req_reg     <= 1'b0;
            wr_reg      <= 1'b0;
            addr_reg    <= 8'h00;
            data_reg    <= 8'h00;
            wr_idx_reg  <= 3'd0;
            rd_idx_reg  <= 3'd0;
            tmo_reg     <= 8'd0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            err_reg     <= 8'h00;
        end else begin
            state_reg   <= state_next;
            cfg_no_reg  <= cfg_no_next;
            req_reg     <= req_next;
            wr_reg      <= wr_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            wr_idx_reg  <= wr_idx_next;
            rd_idx_reg  <= rd_idx_next;
            tmo_reg     <= tmo_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            err_reg     <= err_next;
        end
    end

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            sh_vld_reg <= '0;
            for (int j = 0; j < WR_NUM; j++) begin
                sh_addr_reg[j] <= 8'h00;
                sh_data_reg[j] <= 8'h00;
            end
        end else if (sh_clr) begin
            sh_vld_reg <= '0;
        end else if (sh_we) begin
            for (int j = 0; j < WR_NUM; j++) begin
                if (wr_idx_reg == 3'(j)) begin
                    sh_vld_reg[j]  <= 1'b1;
                    sh_addr_reg[j] <= iCfgAddr;
                    sh_data_reg[j] <= iCfgData;
                end
            end
        end
    end

`ifdef MR_RD_CAPTURE_EN
    logic [7:0] cap_reg [8];

    always_ff @(posedge iClk or negedge iRst_N) begin
        if (!iRst_N) begin
            for (int j = 0; j < 8; j++) cap_reg[j] <= 8'h00;
        end else if (sh_clr) begin
            for (int j = 0; j < 8; j++) cap_reg[j] <= 8'h00;
        end else if (rd_take) begin
            cap_reg[rd_idx_reg] <= iRdData;
        end
    end

    assign oCapData = ({1'b0, iCapSel} < 4'(RD_NUM)) ? cap_reg[iCapSel] : 8'h00;
`endif

    assign oCfgNo   = cfg_no_reg;
    assign oCmdReq  = req_reg;
    assign oCmdWr   = wr_reg;
    assign oCmdAddr = addr_reg;
    assign oCmdData = data_reg;
    assign oBusy    = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign oDone    = done_reg;
    assign oPass    = done_reg && (err_reg == 8'h00) && !timeout_reg;
    assign oTimeout = timeout_reg;
    assign oErrMask = err_reg;
endmodule

// File: tb/tb_octal_ram_mr_readback.sv
// Bench for octal_ram_mr_readback: engine model with a command scoreboard and a table of run scenarios.
module tb_octal_ram_mr_readback;
    logic       iClk = 1'b0;
    logic       iRst_N, iStart, iCmdAck, iRdValid;
    logic [7:0] oCfgNo, iCfgAddr, iCfgData, oCmdAddr, oCmdData, iRdData, oErrMask;
    logic       oCmdReq, oCmdWr, oBusy, oDone, oPass, oTimeout;
`ifdef MR_RD_CAPTURE_EN
    logic [2:0] iCapSel;
    logic [7:0] oCapData;
`endif

    octal_ram_mr_readback dut (
        .iClk(iClk), .iRst_N(iRst_N), .iStart(iStart), .oCfgNo(oCfgNo),
        .iCfgAddr(iCfgAddr), .iCfgData(iCfgData), .oCmdReq(oCmdReq), .oCmdWr(oCmdWr),
        .oCmdAddr(oCmdAddr), .oCmdData(oCmdData), .iCmdAck(iCmdAck), .iRdValid(iRdValid),
        .iRdData(iRdData), .oBusy(oBusy), .oDone(oDone), .oPass(oPass), .oTimeout(oTimeout),
`ifdef MR_RD_CAPTURE_EN
        .iCapSel(iCapSel), .oCapData(oCapData),
`endif
        .oErrMask(oErrMask)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct {
        string      name;
        int         mod_k;       // read index whose returned byte is replaced, -1 none
        logic [7:0] mod_val;
        logic       same_cycle;
        int         never_idx;   // command number left un-acked, -1 none
        logic       busy_start;
        logic [7:0] exp_err;
        logic       exp_pass;
        logic       exp_tmo;
        int         exp_ncmd;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0] cfg_ma  [16];
    logic [7:0] cfg_dat [16];
    logic [7:0] rd_ma   [6];
    logic [7:0] rd_ret  [8];
    cmd_t       sb [$];
    int         ncmd, rdk, never_idx;
    logic       same_cycle;
    vec_t       vecs [6];

    assign iCfgAddr = cfg_ma[oCfgNo[3:0]];
    assign iCfgData = cfg_dat[oCfgNo[3:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine model: ack two cycles after a request, read byte with the ack or one cycle later.
    initial begin
        cmd_t got, want;
        iCmdAck = 1'b0; iRdValid = 1'b0; iRdData = 8'h00;
        forever begin
            @(posedge iClk); #1;
            if (oCmdReq === 1'b1) begin
                got = '{oCmdWr, oCmdAddr, oCmdData};
                if (sb.size() == 0) begin
                    check("unexpected_cmd", {47'd0, got}, 64'h1_FFFF_FFFF);
                end else begin
                    want = sb.pop_front();
                    check("cmd", {47'd0, got}, {47'd0, want});
                end
                $display("cmd %0d wr=%0b ma=%02h data=%02h", ncmd, got.wr, got.addr, got.data);
                ncmd++;
                if (ncmd - 1 == never_idx) begin
                    for (int b = 0; b < 1000 && oCmdReq; b++) begin
                        @(posedge iClk); #1;
                    end
                end else begin
                    @(posedge iClk); #1;
                    iCmdAck = 1'b1;
                    if (!got.wr && same_cycle) begin
                        iRdValid = 1'b1; iRdData = rd_ret[rdk];
                    end
                    @(posedge iClk); #1;
                    iCmdAck = 1'b0; iRdValid = 1'b0;
                    if (!got.wr && !same_cycle) begin
                        iRdValid = 1'b1; iRdData = rd_ret[rdk];
                        @(posedge iClk); #1;
                        iRdValid = 1'b0;
                    end
                    if (!got.wr) rdk++;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int c;
        sb.delete();
        ncmd = 0; rdk = 0;
        never_idx  = v.never_idx;
        same_cycle = v.same_cycle;
        rd_ret = '{8'h28, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
        if (v.mod_k >= 0) rd_ret[v.mod_k] = v.mod_val;
        for (int i = 0; i < 4; i++)
            if (v.never_idx < 0 || i <= v.never_idx) sb.push_back('{1'b1, cfg_ma[i], cfg_dat[i]});
        if (v.never_idx < 0)
            for (int k = 0; k < 6; k++) sb.push_back('{1'b0, rd_ma[k], 8'h00});
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        check({v.name, "_busy_run"}, {63'd0, oBusy}, 64'd1);
        if (v.busy_start) begin
            repeat (20) @(posedge iClk);
            #1 iStart = 1'b1;
            @(posedge iClk); #1;
            iStart = 1'b0;
        end
        for (c = 0; c < 2000 && !oDone; c++) begin
            @(posedge iClk); #1;
        end
        repeat (3) @(posedge iClk);
        #1;
        check({v.name, "_done"},  {63'd0, oDone}, 64'd1);
        check({v.name, "_busy"},  {63'd0, oBusy}, 64'd0);
        check({v.name, "_pass"},  {63'd0, oPass}, {63'd0, v.exp_pass});
        check({v.name, "_tmo"},   {63'd0, oTimeout}, {63'd0, v.exp_tmo});
        check({v.name, "_err"},   {56'd0, oErrMask}, {56'd0, v.exp_err});
        check({v.name, "_req"},   {63'd0, oCmdReq}, 64'd0);
        check({v.name, "_ncmd"},  64'(ncmd), 64'(v.exp_ncmd));
        check({v.name, "_sbleft"}, 64'(sb.size()), 64'd0);
        $display("run %s done=%0b pass=%0b tmo=%0b err=%02h cmds=%0d", v.name, oDone, oPass,
                 oTimeout, oErrMask, ncmd);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin cfg_ma[i] = 8'h00; cfg_dat[i] = 8'h00; end
        cfg_ma[0] = 8'h00; cfg_dat[0] = 8'h28;
        cfg_ma[1] = 8'h04; cfg_dat[1] = 8'h40;
        cfg_ma[2] = 8'h06; cfg_dat[2] = 8'hF0;
        cfg_ma[3] = 8'h08; cfg_dat[3] = 8'h00;
        rd_ma = '{8'h00, 8'h08, 8'h01, 8'h02, 8'h04, 8'h05};
        for (int k = 0; k < 6; k++) cfg_ma[4 + k] = rd_ma[k];
        //          name      mod_k val    same never busy  err    pass  tmo  ncmd
        vecs[0] = '{"basic",   -1, 8'h00, 1'b0, -1, 1'b0, 8'h00, 1'b1, 1'b0, 10};
        vecs[1] = '{"mis_ma04", 4, 8'h47, 1'b0, -1, 1'b0, 8'h10, 1'b0, 1'b0, 10};
        vecs[2] = '{"no_ack",  -1, 8'h00, 1'b0,  1, 1'b0, 8'h00, 1'b0, 1'b1, 2};
        vecs[3] = '{"same_cyc",-1, 8'h00, 1'b1, -1, 1'b0, 8'h00, 1'b1, 1'b0, 10};
        vecs[4] = '{"mis_ma08", 1, 8'h01, 1'b1, -1, 1'b1, 8'h02, 1'b0, 1'b0, 10};
        vecs[5] = '{"unwr_ma",  2, 8'h55, 1'b0, -1, 1'b0, 8'h00, 1'b1, 1'b0, 10};
        never_idx = -1; same_cycle = 1'b0; ncmd = 0; rdk = 0;
        rd_ret = '{8'h28, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
`ifdef MR_RD_CAPTURE_EN
        iCapSel = 3'd0;
`endif
        iRst_N = 1'b0; iStart = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        check("reset_outs", {26'd0, oCfgNo, oCmdReq, oCmdWr, oCmdAddr, oCmdData, oBusy, oDone,
                             oPass, oTimeout, oErrMask}, 64'd0);
        iRst_N = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        check("idle_busy", {63'd0, oBusy}, 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

`ifdef MR_RD_CAPTURE_EN
        run_vec(vecs[0]);
        for (int s = 0; s < 8; s++) begin
            logic [7:0] exp_cap;
            iCapSel = 3'(s);
            exp_cap = (s < 6) ? rd_ret[s] : 8'h00;
            #1 check("cap_data", {56'd0, oCapData}, {56'd0, exp_cap});
            $display("cap sel=%0d data=%02h", s, oCapData);
        end
`endif

        // Abort during the third read, then a fresh run must complete cleanly.
        sb.delete();
        ncmd = 0; rdk = 0; never_idx = -1; same_cycle = 1'b0;
        for (int i = 0; i < 4; i++) sb.push_back('{1'b1, cfg_ma[i], cfg_dat[i]});
        for (int k = 0; k < 6; k++) sb.push_back('{1'b0, rd_ma[k], 8'h00});
        iStart = 1'b1;
        @(posedge iClk); #1;
        iStart = 1'b0;
        for (int c = 0; c < 500 && ncmd < 7; c++) @(posedge iClk);
        check("abort_reached_rd3", 64'(ncmd), 64'd7);
        #2 iRst_N = 1'b0;
        #1;
        check("abort_req", {63'd0, oCmdReq}, 64'd0);
        check("abort_outs", {26'd0, oCfgNo, oCmdReq, oCmdWr, oCmdAddr, oCmdData, oBusy, oDone,
                             oPass, oTimeout, oErrMask}, 64'd0);
        $display("abort reset at cmd %0d", ncmd);
        repeat (10) @(posedge iClk);
        #1 iRst_N = 1'b1;
        repeat (3) @(posedge iClk);
        #1;
        check("abort_idle", {63'd0, oBusy}, 64'd0);
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
